sao_stat_collect: RTL and testbench

Per-CTU statistics collector for SAO edge-offset decision. Accepts one pixel per cycle with its EO category and clipped difference (orig − rec), and accumulates a signed sum and a pixel count per category over one CTU. At CTU end it drains the four (sum, count) pairs over a valid/ready handshake to `sao_deci_init_offset`, which turns each pair into a rounded, clipped initial offset.

---
 rtl/sao_stat_collect.sv | 177 +++++++++++++++++
 tb/tb_sao_stat_collect.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sao_stat_collect.sv
// SAO edge-offset statistics collector: per-CTU signed sum and pixel count for EO categories 1..4,
// drained as four (sum, count) entries. Optional macro SAO_STAT_ZERO_SKIP_EN skips empty entries 0..2.
module sao_stat_collect #(
  parameter int num_pix_CTU_log2 = 5,
  parameter int num_CTU          = num_pix_CTU_log2 * 2,
  parameter int offset_len       = 4,
  parameter int sum_CTU_len      = num_CTU + offset_len
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          pix_valid,
  output logic                          in_ready,
  input  logic [2:0]                    pix_cat,
  input  logic signed [offset_len-1:0]  pix_diff,
  input  logic                          pix_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_cat,
  output logic signed [sum_CTU_len-1:0] sum_blk_CTU,
  output logic [num_CTU-1:0]            num_blk_CTU,
  output logic                          out_last
);

  typedef enum logic [0:0] {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [num_CTU-1:0]     NUM_MAX  = {num_CTU{1'b1}};
  localparam logic [num_CTU-1:0]     NUM_ONE  = {{(num_CTU-1){1'b0}}, 1'b1};
  localparam logic [num_CTU-1:0]     NUM_ZERO = {num_CTU{1'b0}};
  localparam logic [sum_CTU_len-1:0] SUM_ZERO = {sum_CTU_len{1'b0}};

  state_t                         state_r, state_s;
  logic [1:0]                     ptr_r, ptr_s;
  logic signed [sum_CTU_len-1:0]  sum_r [4];
  logic signed [sum_CTU_len-1:0]  sum_s [4];
  logic [num_CTU-1:0]             num_r [4];
  logic [num_CTU-1:0]             num_s [4];

  logic                           accept_s;
  logic                           cat_hit_s;
  logic [1:0]                     cat_idx_s;
  logic signed [sum_CTU_len-1:0]  diff_ext_s;
  logic [1:0]                     emit_ptr_s;
  logic                           emit_last_s;
  logic                           drain_hs_s;

`ifdef SAO_STAT_ZERO_SKIP_EN
  logic [2:0] nz_s;

  // First entry at or after p whose count is nonzero; entry 3 is the fallback.
  function automatic logic [1:0] skip_ptr(input logic [1:0] p, input logic [2:0] nz);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      if ((i >= int'(p)) && nz[i]) begin
        r = i[1:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  // Beat qualification, category decode and sign extension of the difference.
  always_comb begin
    accept_s   = pix_valid && (state_r == ST_ACC);
    cat_hit_s  = (pix_cat >= 3'd1) && (pix_cat <= 3'd4);
    cat_idx_s  = pix_cat[1:0] - 2'd1;
    diff_ext_s = {{(sum_CTU_len-offset_len){pix_diff[offset_len-1]}}, pix_diff};
  end

  // Entry selection for the drain; with zero-skip the emitted index jumps over empty entries.
  always_comb begin
`ifdef SAO_STAT_ZERO_SKIP_EN
    for (int i = 0; i < 3; i++) begin
      nz_s[i] = (num_r[i] != NUM_ZERO);
    end
    emit_ptr_s = skip_ptr(ptr_r, nz_s);
`else
    emit_ptr_s = ptr_r;
`endif
    emit_last_s = (emit_ptr_s == 2'd3);
    drain_hs_s  = (state_r == ST_DRAIN) && out_ready;
  end

  // Next-state and drain pointer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_ACC: begin
        if (accept_s && pix_last) begin
          state_s = ST_DRAIN;
          ptr_s   = 2'd0;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (out_ready && emit_last_s) begin
          state_s = ST_ACC;
          ptr_s   = 2'd0;
        end else if (out_ready) begin
          ptr_s   = emit_ptr_s + 2'd1;
        end else begin
          ptr_s   = ptr_r;
        end
      end
      default: begin
        state_s = ST_ACC;
        ptr_s   = 2'd0;
      end
    endcase
  end

  // Accumulator update; cleared by the final drain handshake, count saturates.
  always_comb begin
    sum_s = sum_r;
    num_s = num_r;
    if (drain_hs_s && emit_last_s) begin
      for (int i = 0; i < 4; i++) begin
        sum_s[i] = SUM_ZERO;
        num_s[i] = NUM_ZERO;
      end
    end else if (accept_s && cat_hit_s) begin
      sum_s[cat_idx_s] = sum_r[cat_idx_s] + diff_ext_s;
      if (num_r[cat_idx_s] != NUM_MAX) begin
        num_s[cat_idx_s] = num_r[cat_idx_s] + NUM_ONE;
      end else begin
        num_s[cat_idx_s] = NUM_MAX;
      end
    end else begin
      sum_s = sum_r;
    end
  end

  // State, pointer and accumulator registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_ACC;
      ptr_r   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        sum_r[i] <= SUM_ZERO;
        num_r[i] <= NUM_ZERO;
      end
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      for (int i = 0; i < 4; i++) begin
        sum_r[i] <= sum_s[i];
        num_r[i] <= num_s[i];
      end
    end
  end

  // Output decode straight from registers; idle outputs are forced to zero.
  always_comb begin
    in_ready = (state_r == ST_ACC);
    if (state_r == ST_DRAIN) begin
      out_valid   = 1'b1;
      out_cat     = emit_ptr_s;
      sum_blk_CTU = sum_r[emit_ptr_s];
      num_blk_CTU = num_r[emit_ptr_s];
      out_last    = emit_last_s;
    end else begin
      out_valid   = 1'b0;
      out_cat     = 2'd0;
      sum_blk_CTU = SUM_ZERO;
      num_blk_CTU = NUM_ZERO;
      out_last    = 1'b0;
    end
  end

endmodule

// File: tb/tb_sao_stat_collect.sv
// Directed bench for sao_stat_collect: a cycle table for the mixed stream plus
// hand sequences for idle, backpressure, saturation, mid-drain reset and ignored categories.
module tb_sao_stat_collect;

  logic              clk;
  logic              arst_n;
  logic              pix_valid;
  logic              in_ready;
  logic [2:0]        pix_cat;
  logic signed [3:0] pix_diff;
  logic              pix_last;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_cat;
  logic signed [13:0] sum_blk_CTU;
  logic [9:0]        num_blk_CTU;
  logic              out_last;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  sao_stat_collect dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .pix_valid   (pix_valid),
    .in_ready    (in_ready),
    .pix_cat     (pix_cat),
    .pix_diff    (pix_diff),
    .pix_last    (pix_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cat     (out_cat),
    .sum_blk_CTU (sum_blk_CTU),
    .num_blk_CTU (num_blk_CTU),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   cat;
    int   diff;
    logic last;
    logic ordy;
    logic e_ov;
    logic e_ir;
    int   e_cat;
    int   e_sum;
    int   e_num;
    logic e_last;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input int d, input bit l);
    pix_valid = 1'b1;
    pix_cat   = c[2:0];
    pix_diff  = d[3:0];
    pix_last  = l;
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic expect_entry(input string nm, input int c, input int s, input int n);
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 8) begin
      step();
      guard++;
    end
    if (out_valid !== 1'b1) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s_timeout: got out_valid=%0b expected 1", nm, out_valid);
    end else begin
      chk({nm, "_cat"}, int'(out_cat), c);
      chk({nm, "_sum"}, int'(sum_blk_CTU), s);
      chk({nm, "_num"}, int'(num_blk_CTU), n);
      chk({nm, "_last"}, int'(out_last), (c == 3) ? 1 : 0);
      chk({nm, "_irdy"}, int'(in_ready), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic expect_zero_from(input string nm, input int start);
    for (int k = start; k < 4; k++) begin
`ifdef SAO_STAT_ZERO_SKIP_EN
      if (k != 3) continue;
`endif
      expect_entry(nm, k, 0, 0);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_ov"}, int'(out_valid), 0);
    chk({nm, "_ir"}, int'(in_ready), 1);
    chk({nm, "_cat"}, int'(out_cat), 0);
    chk({nm, "_sum"}, int'(sum_blk_CTU), 0);
    chk({nm, "_num"}, int'(num_blk_CTU), 0);
    chk({nm, "_last"}, int'(out_last), 0);
  endtask

  initial begin
    // Mixed stream: cat1 {3,-2,7}, cat2 {-8,-8}, cat4 {1}, last on final beat, then drain.
    tbl[0] = '{1'b1, 1,  3, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[1] = '{1'b1, 1, -2, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[2] = '{1'b1, 1,  7, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[3] = '{1'b1, 2, -8, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[4] = '{1'b1, 2, -8, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[5] = '{1'b1, 4,  1, 1'b1, 1'b1, 1'b1, 1'b0, 0,   8, 3, 1'b0};
    tbl[6] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1, -16, 2, 1'b0};
`ifdef SAO_STAT_ZERO_SKIP_EN
    tbl[7] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 3,   1, 1, 1'b1};
    tbl[8] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 0,   0, 0, 1'b0};
    tbl[9] = '{1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0, 0, 1'b0};
`else
    tbl[7] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 2,   0, 0, 1'b0};
    tbl[8] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 3,   1, 1, 1'b1};
    tbl[9] = '{1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 0,   0, 0, 1'b0};
`endif

    arst_n    = 1'b0;
    pix_valid = 1'b0;
    pix_cat   = 3'd0;
    pix_diff  = 4'sd0;
    pix_last  = 1'b0;
    out_ready = 1'b0;
    #12;
    check_idle("reset_hold");
    arst_n = 1'b1;
    step();
    check_idle("reset_rel");

    // Idle: out_ready high with nothing pending has no effect.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ov", int'(out_valid), 0);
      chk("idle_ir", int'(in_ready), 1);
    end
    out_ready = 1'b0;

    // One CTU of 1024 cat-0 pixels: all entries empty.
    for (int i = 0; i < 1024; i++) send(0, 0, (i == 1023));
    chk("cat0_ctu_ov", int'(out_valid), 1);
    expect_zero_from("cat0_ctu", 0);
    check_idle("cat0_done");

    // Cycle table.
    for (int i = 0; i < 10; i++) begin
      pix_valid = tbl[i].v;
      pix_cat   = tbl[i].cat[2:0];
      pix_diff  = tbl[i].diff[3:0];
      pix_last  = tbl[i].last;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_ov", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ir", i), int'(in_ready), int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_cat", i), int'(out_cat), tbl[i].e_cat);
      chk($sformatf("tbl%0d_sum", i), int'(sum_blk_CTU), tbl[i].e_sum);
      chk($sformatf("tbl%0d_num", i), int'(num_blk_CTU), tbl[i].e_num);
      chk($sformatf("tbl%0d_last", i), int'(out_last), int'(tbl[i].e_last));
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    out_ready = 1'b0;

    // Backpressure at ptr 1 with a pixel held on the input.
    send(1, 3, 1'b0); send(1, -2, 1'b0); send(1, 7, 1'b0);
    send(2, -8, 1'b0); send(2, -8, 1'b0); send(4, 1, 1'b1);
    expect_entry("bp_e0", 0, 8, 3);
    pix_valid = 1'b1;
    pix_cat   = 3'd1;
    pix_diff  = 4'sd5;
    pix_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_cat", int'(out_cat), 1);
      chk("bp_hold_sum", int'(sum_blk_CTU), -16);
      chk("bp_hold_num", int'(num_blk_CTU), 2);
      chk("bp_hold_ir", int'(in_ready), 0);
    end
    expect_entry("bp_e1", 1, -16, 2);
`ifndef SAO_STAT_ZERO_SKIP_EN
    expect_entry("bp_e2", 2, 0, 0);
`endif
    expect_entry("bp_e3", 3, 1, 1);
    chk("bp_after_ir", int'(in_ready), 1);
    chk("bp_after_ov", int'(out_valid), 0);
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    chk("bp_held_acc_ov", int'(out_valid), 1);
    expect_entry("bp_new_e0", 0, 5, 1);
    expect_zero_from("bp_new", 1);

    // Saturation: 1024 cat3 pixels of -8.
    for (int i = 0; i < 1024; i++) send(3, -8, (i == 1023));
`ifndef SAO_STAT_ZERO_SKIP_EN
    expect_entry("sat_e0", 0, 0, 0);
    expect_entry("sat_e1", 1, 0, 0);
`endif
    expect_entry("sat_e2", 2, -8192, 1023);
    expect_zero_from("sat", 3);

    // Reset at ptr 2 discards the CTU.
    send(1, 3, 1'b0); send(2, -1, 1'b0); send(3, 2, 1'b1);
    expect_entry("rst_e0", 0, 3, 1);
    expect_entry("rst_e1", 1, -1, 1);
    chk("rst_at_ptr2", int'(out_cat), 2);
    #2;
    arst_n = 1'b0;
    #1;
    chk("rst_ov_drop", int'(out_valid), 0);
    chk("rst_ir", int'(in_ready), 1);
    #5;
    arst_n = 1'b1;
    step();
    send(1, 5, 1'b1);
    expect_entry("rst_new_e0", 0, 5, 1);
    expect_zero_from("rst_new", 1);

    // Ignored categories interleaved with cat2 diff 4.
    send(5, 7, 1'b0); send(0, -3, 1'b0); send(2, 4, 1'b0); send(7, -8, 1'b0);
    send(2, 4, 1'b0); send(6, 1, 1'b0); send(0, 2, 1'b0); send(2, 4, 1'b1);
`ifndef SAO_STAT_ZERO_SKIP_EN
    expect_entry("ign_e0", 0, 0, 0);
`endif
    expect_entry("ign_e1", 1, 12, 3);
    expect_zero_from("ign", 2);
    check_idle("ign_done");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
